// File: rtl/nrzi_tx_controller.sv
// Transmit sequencer feeding the NRZI encoder x input: frames bytes as sync, LSB-first
// data with zero stuffing after STUFF_LEN ones, and an EOP run of ones.
module nrzi_tx_controller #(
  parameter logic [7:0] SYNC_PATTERN = 8'h80,
  parameter int         STUFF_LEN    = 6,
  parameter int         EOP_LEN      = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       frame_last,
  output logic       data_ready,
  output logic       x_out,
  output logic       tx_active,
  output logic       stuff_bit,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [3:0] L_STUFF    = 4'(STUFF_LEN);
  localparam logic [2:0] L_EOP_LAST = 3'(EOP_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_EOP} state_t;

  state_t     r_state, w_state;
  logic [7:0] r_shift, w_shift;
  logic [7:0] r_buf, w_buf;
  logic       r_buf_last, w_buf_last;
  logic       r_buf_full, w_buf_full;
  logic       r_last_taken, w_last_taken;
  logic       r_cur_last, w_cur_last;
  logic       r_tail, w_tail;
  logic [2:0] r_bitcnt, w_bitcnt;
  logic [2:0] r_eopcnt, w_eopcnt;
  logic [3:0] r_ones, w_ones;
  logic       r_x, w_x;
  logic       r_active, w_active;
  logic       r_stuff, w_stuff;
  logic       r_done, w_done;
  logic       r_under, w_under;
  logic       w_accept;
  logic       w_finish;

  assign data_ready = !r_buf_full & !r_last_taken;
  assign w_accept   = data_valid & data_ready;

  always_comb begin
    w_state      = r_state;
    w_shift      = r_shift;
    w_buf        = r_buf;
    w_buf_last   = r_buf_last;
    w_buf_full   = r_buf_full;
    w_last_taken = r_last_taken;
    w_cur_last   = r_cur_last;
    w_tail       = r_tail;
    w_bitcnt     = r_bitcnt;
    w_eopcnt     = r_eopcnt;
    w_ones       = r_ones;
    w_x          = 1'b1;
    w_active     = 1'b0;
    w_stuff      = 1'b0;
    w_done       = 1'b0;
    w_under      = 1'b0;
    w_finish     = 1'b0;

    if (w_accept) begin
      w_buf      = data_in;
      w_buf_last = frame_last;
      w_buf_full = 1'b1;
      if (frame_last) w_last_taken = 1'b1;
    end

    unique case (r_state)
      S_IDLE: begin
        w_ones = '0;
        if (w_accept) begin
          w_state    = S_SYNC;
          w_shift    = SYNC_PATTERN;
          w_bitcnt   = '0;
          w_cur_last = 1'b0;
          w_tail     = 1'b0;
        end
      end

      S_SYNC, S_DATA: begin
        w_active = 1'b1;
        if (r_ones == L_STUFF) begin
          // Stuffed zero: shifter and bit counter hold.
          w_x     = 1'b0;
          w_stuff = 1'b1;
          w_ones  = '0;
          if (r_tail) begin
            w_tail   = 1'b0;
            w_state  = S_EOP;
            w_eopcnt = '0;
          end
        end else begin
          w_x      = r_shift[0];
          w_shift  = {1'b0, r_shift[7:1]};
          w_ones   = r_shift[0] ? r_ones + 4'd1 : 4'd0;
          w_bitcnt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            if (r_cur_last) begin
              w_finish = 1'b1;
            end else if (r_buf_full) begin
              w_shift    = r_buf;
              w_cur_last = r_buf_last;
              w_buf_full = 1'b0;
              w_state    = S_DATA;
            end else if (w_accept) begin
              // Byte arriving on the boundary edge goes straight to the shifter.
              w_shift    = data_in;
              w_cur_last = frame_last;
              w_buf_full = 1'b0;
              w_state    = S_DATA;
            end else begin
              // Aborted frame accepts nothing more until it is back in IDLE.
              w_under      = 1'b1;
              w_last_taken = 1'b1;
              w_finish     = 1'b1;
            end
          end
          if (w_finish) begin
            if (w_ones == L_STUFF) begin
              w_tail  = 1'b1;
              w_state = S_DATA;
            end else begin
              w_state  = S_EOP;
              w_eopcnt = '0;
            end
          end
        end
      end

      S_EOP: begin
        w_active = 1'b1;
        w_eopcnt = r_eopcnt + 3'd1;
        if (r_eopcnt == L_EOP_LAST) begin
          w_done       = 1'b1;
          w_state      = S_IDLE;
          w_last_taken = 1'b0;
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_buf        <= '0;
      r_buf_last   <= 1'b0;
      r_buf_full   <= 1'b0;
      r_last_taken <= 1'b0;
      r_cur_last   <= 1'b0;
      r_tail       <= 1'b0;
      r_bitcnt     <= '0;
      r_eopcnt     <= '0;
      r_ones       <= '0;
      r_x          <= 1'b1;
      r_active     <= 1'b0;
      r_stuff      <= 1'b0;
      r_done       <= 1'b0;
      r_under      <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_shift      <= w_shift;
      r_buf        <= w_buf;
      r_buf_last   <= w_buf_last;
      r_buf_full   <= w_buf_full;
      r_last_taken <= w_last_taken;
      r_cur_last   <= w_cur_last;
      r_tail       <= w_tail;
      r_bitcnt     <= w_bitcnt;
      r_eopcnt     <= w_eopcnt;
      r_ones       <= w_ones;
      r_x          <= w_x;
      r_active     <= w_active;
      r_stuff      <= w_stuff;
      r_done       <= w_done;
      r_under      <= w_under;
    end
  end

  assign x_out      = r_x;
  assign tx_active  = r_active;
  assign stuff_bit  = r_stuff;
  assign frame_done = r_done;
  assign underrun   = r_under;

endmodule

// File: tb/tb_nrzi_tx_controller.sv
// Bench for nrzi_tx_controller: fixed vector table, directed corner sequences and
// randomized frames checked cycle by cycle against a queue-based line model.
module tb_nrzi_tx_controller;
  localparam logic [7:0] SYNC  = 8'h80;
  localparam int         STUFF = 6;
  localparam int         EOPL  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       frame_last = 1'b0;
  logic       data_ready, x_out, tx_active, stuff_bit, frame_done, underrun;

  int checks = 0;
  int errors = 0;
  int act_cnt = 0;
  int und_cnt = 0;

  nrzi_tx_controller #(.SYNC_PATTERN(SYNC), .STUFF_LEN(STUFF), .EOP_LEN(EOPL)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .frame_last(frame_last), .data_ready(data_ready), .x_out(x_out),
    .tx_active(tx_active), .stuff_bit(stuff_bit), .frame_done(frame_done),
    .underrun(underrun)
  );

  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Line model: a queue of raw bits still to be sent, a one-entry byte queue for the
  // buffer, and a running count of consecutive ones for stuffing.
  typedef struct {logic [7:0] d; bit last;} mbyte_t;
  bit     mq[$];
  mbyte_t mbuf[$];
  int     m_ones, m_eop, m_mode;
  bit     m_closed, m_cur_last;
  bit     e_x, e_act, e_stf, e_done, e_und;

  function automatic bit m_ready();
    return (mbuf.size() == 0) && !m_closed;
  endfunction

  function automatic void m_reset();
    mq.delete();
    mbuf.delete();
    m_ones = 0; m_eop = 0; m_mode = 0; m_closed = 0; m_cur_last = 0;
    e_x = 1; e_act = 0; e_stf = 0; e_done = 0; e_und = 0;
  endfunction

  function automatic void m_push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) mq.push_back(b[i]);
  endfunction

  function automatic void m_step(input bit v, input bit l, input logic [7:0] d);
    bit acc, used, fin, b;
    mbyte_t t;
    acc = v && m_ready();
    used = 0; fin = 0;
    e_x = 1; e_act = 0; e_stf = 0; e_done = 0; e_und = 0;
    case (m_mode)
      0: begin
        m_ones = 0;
        if (acc) begin
          m_push_byte(SYNC);
          m_cur_last = 0;
          m_mode = 1;
        end
      end
      1: begin
        e_act = 1;
        if (m_ones == STUFF) begin
          e_x = 0; e_stf = 1; m_ones = 0;
        end else begin
          b = mq.pop_front();
          e_x = b;
          m_ones = b ? m_ones + 1 : 0;
          if (mq.size() == 0) begin
            if (m_cur_last) fin = 1;
            else if (mbuf.size() != 0) begin
              t = mbuf.pop_front();
              m_push_byte(t.d);
              m_cur_last = t.last;
            end else if (acc) begin
              m_push_byte(d);
              m_cur_last = l;
              used = 1;
            end else begin
              e_und = 1; m_closed = 1; fin = 1;
            end
            if (fin) begin
              m_mode = (m_ones == STUFF) ? 2 : 3;
              m_eop = EOPL;
            end
          end
        end
      end
      2: begin
        e_act = 1; e_x = 0; e_stf = 1; m_ones = 0; m_mode = 3;
      end
      default: begin
        e_act = 1;
        m_eop--;
        if (m_eop == 0) begin
          e_done = 1; m_mode = 0; m_closed = 0;
        end
      end
    endcase
    if (acc && !used) mbuf.push_back('{d, l});
    if (acc && l) m_closed = 1;
  endfunction

  // One clock: drive, check ready before the edge, step the model, check after the edge.
  task automatic drive_cycle(input bit v, input bit l, input logic [7:0] d);
    data_valid = v; frame_last = l; data_in = d;
    chk("data_ready", data_ready, m_ready());
    @(posedge clock);
    m_step(v, l, d);
    @(negedge clock);
    chk("x_out", x_out, e_x);
    chk("tx_active", tx_active, e_act);
    chk("stuff_bit", stuff_bit, e_stf);
    chk("frame_done", frame_done, e_done);
    chk("underrun", underrun, e_und);
    act_cnt += int'(tx_active);
    und_cnt += int'(underrun);
  endtask

  task automatic run_frame(input logic [7:0] bs[4], input int nbytes, input int offer,
                           input bit always_valid);
    int k = 0;
    bit started = 0, finished = 0;
    for (int c = 0; c < 400 && !finished; c++) begin
      bit v, acc;
      v = (k < offer) && (always_valid || ($urandom_range(3) != 0));
      acc = v && m_ready();
      drive_cycle(v, (k == nbytes - 1), (k < offer) ? bs[k] : 8'h00);
      if (acc) k++;
      if (m_mode != 0) started = 1;
      else if (started) finished = 1;
    end
    chk_int("frame_terminates", int'(finished), 1);
  endtask

  typedef struct {bit v; bit l; logic [7:0] d; bit x, a, s, dn, u, r;} vec_t;
  vec_t tbl[$];

  function automatic void addv(input bit v, input bit l, input logic [7:0] d, input bit x,
                               input bit a, input bit s, input bit dn, input bit u, input bit r);
    tbl.push_back('{v, l, d, x, a, s, dn, u, r});
  endfunction

  initial begin
    logic [7:0] sp;
    logic [7:0] bs[4];
    bit a5bits[8];
    sp = SYNC;
    a5bits = '{1, 0, 1, 0, 0, 1, 0, 1};

    // Frame 1: 8'hA5 last -> 18 active cycles.
    addv(1, 1, 8'hA5, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) addv(0, 0, 8'h00, sp[i], 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) addv(0, 0, 8'h00, a5bits[i], 1, 0, 0, 0, 0);
    addv(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
    addv(0, 0, 8'h00, 1, 1, 0, 1, 0, 1);
    addv(0, 0, 8'h00, 1, 0, 0, 0, 0, 1);
    // Frame 2: 8'hFF last -> five ones, stuffed zero, three ones, EOP.
    addv(1, 1, 8'hFF, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) addv(0, 0, 8'h00, sp[i], 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) addv(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
    addv(0, 0, 8'h00, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) addv(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
    addv(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
    addv(0, 0, 8'h00, 1, 1, 0, 1, 0, 1);
    addv(0, 0, 8'h00, 1, 0, 0, 0, 0, 1);

    m_reset();
    #1 reset = 1'b1;
    #2;
    chk("rst_x_out", x_out, 1'b1);
    chk("rst_tx_active", tx_active, 1'b0);
    chk("rst_data_ready", data_ready, 1'b1);
    chk("rst_frame_done", frame_done, 1'b0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) drive_cycle(0, 0, 8'h00);

    foreach (tbl[i]) begin
      data_valid = tbl[i].v; frame_last = tbl[i].l; data_in = tbl[i].d;
      @(posedge clock);
      m_step(tbl[i].v, tbl[i].l, tbl[i].d);
      @(negedge clock);
      chk($sformatf("tbl%0d_x", i), x_out, tbl[i].x);
      chk($sformatf("tbl%0d_act", i), tx_active, tbl[i].a);
      chk($sformatf("tbl%0d_stuff", i), stuff_bit, tbl[i].s);
      chk($sformatf("tbl%0d_done", i), frame_done, tbl[i].dn);
      chk($sformatf("tbl%0d_und", i), underrun, tbl[i].u);
      chk($sformatf("tbl%0d_ready", i), data_ready, tbl[i].r);
    end

    // Three streamed bytes: no underrun, 8 + 24 + 2 active cycles.
    bs = '{8'h01, 8'h02, 8'h03, 8'h00};
    act_cnt = 0; und_cnt = 0;
    run_frame(bs, 3, 3, 1);
    chk_int("three_active_cycles", act_cnt, 34);
    chk_int("three_underruns", und_cnt, 0);

    // Underrun after one non-last byte: 8 + 8 + 2 active cycles.
    bs = '{8'h3C, 8'h00, 8'h00, 8'h00};
    act_cnt = 0; und_cnt = 0;
    run_frame(bs, 2, 1, 1);
    chk_int("underrun_active_cycles", act_cnt, 18);
    chk_int("underrun_pulses", und_cnt, 1);
    drive_cycle(0, 0, 8'h00);

    // Mid-frame reset while DATA bit 3 of 8'h00 is on the line.
    drive_cycle(1, 1, 8'h00);
    repeat (12) drive_cycle(0, 0, 8'h00);
    #1 reset = 1'b1;
    #1;
    chk("midrst_x_out", x_out, 1'b1);
    chk("midrst_tx_active", tx_active, 1'b0);
    chk("midrst_stuff_bit", stuff_bit, 1'b0);
    chk("midrst_frame_done", frame_done, 1'b0);
    chk("midrst_underrun", underrun, 1'b0);
    chk("midrst_data_ready", data_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_reset();
    bs = '{8'hC3, 8'h00, 8'h00, 8'h00};
    act_cnt = 0;
    run_frame(bs, 1, 1, 1);
    chk_int("postrst_active_cycles", act_cnt, 18);

    // Randomized frames, biased toward 8'hFF to exercise stuffing.
    for (int f = 0; f < 150; f++) begin
      int nb, off;
      nb = $urandom_range(4, 1);
      off = ($urandom_range(5) == 0) ? $urandom_range(nb - 1, 0) : nb;
      if (off == 0) off = 1;
      for (int j = 0; j < 4; j++) bs[j] = ($urandom_range(2) == 0) ? 8'hFF : 8'($urandom);
      run_frame(bs, nb, off, 1'($urandom_range(1)));
      repeat ($urandom_range(2)) drive_cycle(0, 0, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nrzi_tx_controller.md
# nrzi_tx_controller

Transmit sequencer that sits in front of the Mealy NRZI encoder and drives its `x` input. It accepts bytes over a valid/ready handshake and frames each packet as sync pattern, data bits (LSB-first) and end-of-packet. It inserts a stuffed 0 after `STUFF_LEN` consecutive 1s so the encoded line keeps toggling. When idle it holds `x` at 1, which holds the encoder output steady.

## Interface
- `SYNC_PATTERN`, default 8'h80: sync byte, sent LSB-first (bit sequence 0000_0001).
- `STUFF_LEN`, default 6: number of consecutive 1s after which a 0 is inserted; legal range 2..15.
- `EOP_LEN`, default 2: number of EOP bit cycles; legal range 1..7.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high.
- `data_in`  in  8  byte to transmit.
- `data_valid`  in  1  `data_in` and `frame_last` are valid.
- `frame_last`  in  1  the byte offered is the last byte of the frame.
- `data_ready`  out  1  controller accepts the byte this cycle.
- `x_out`  out  1  serial bit to the NRZI encoder `x` input; registered.
- `tx_active`  out  1  high while a frame (sync, data, stuff or EOP bits) is on `x_out`; registered.
- `stuff_bit`  out  1  high in each cycle `x_out` carries a stuffed 0.
- `frame_done`  out  1  one-cycle pulse coincident with the final EOP bit.
- `underrun`  out  1  one-cycle pulse when a frame is aborted for lack of data.

## Operation
- Handshake and buffer:
  - A byte is accepted when `data_valid & data_ready`.
  - The controller has a one-byte holding buffer (`buf`, `buf_last`) and an 8-bit shifter.
  - `data_ready` is combinational from registered state only: `data_ready = !buf_full & !last_taken`.
  - `last_taken` sets when a byte with `frame_last=1` is accepted and clears on return to IDLE.
- States: IDLE, SYNC, DATA, EOP.
- IDLE:
  - `x_out=1`, `tx_active=0`.
  - An accept loads `buf` and moves to SYNC.
  - The ones counter clears.
- SYNC:
  - Shifts out `SYNC_PATTERN` LSB-first, 8 cycles, with stuffing rules applied.
  - After bit 7 the shifter loads from `buf` (`buf_full` clears) and the state moves to DATA.
- DATA:
  - Shifts `data_in` bits LSB-first, one per cycle.
  - After bit 7: if the current byte was last, go to EOP. Otherwise, if `buf_full`, reload the shifter from `buf` and stay in DATA.
  - Otherwise pulse `underrun` and go to EOP. The aborted frame still gets a full EOP.
- Bit stuffing (SYNC and DATA only):
  - The ones counter increments on each emitted 1 and clears on each emitted 0, including stuffed 0s.
  - When the counter equals `STUFF_LEN`, the next cycle emits 0 with `stuff_bit=1`. The shifter does not advance.
  - A stuff pending after the last data bit is emitted before EOP.
- EOP:
  - `x_out=1` for `EOP_LEN` cycles, with no stuffing.
  - `frame_done` pulses on the last EOP cycle, then the state returns to IDLE.
  - `last_taken` clears, so `data_ready` returns to 1.
- Concurrency:
  - An accept in the same cycle the buffer is consumed is impossible, because `data_ready=0` while `buf_full`.
  - `data_valid` dropping mid-frame is legal. Only the byte-boundary check matters.
- Reset, at assertion or mid-frame, immediately forces:
  - state=IDLE, `x_out=1`, `tx_active=0`, `stuff_bit=0`, `frame_done=0`, `underrun=0`, `buf_full=0`, `last_taken=0`, ones counter=0.
  - `data_ready` reads 1.
  - Any partial frame is dropped, with no EOP.

## Timing
- Accept at edge N (IDLE): sync bit 0 appears on `x_out` after edge N+1. `tx_active` rises at the same edge.
- Sync occupies cycles 1–8. The first data bit is at cycle 9 unless a stuff is pending.
- Each data byte takes 8 cycles plus one per stuffed bit. Stuffed bits do not consume buffer data.
- Frame length in cycles is 8 + 8·bytes + stuffs + `EOP_LEN`. `tx_active` is high for exactly that many cycles.
- Back-to-back frames: a new accept is possible in the first IDLE cycle. The minimum gap is one IDLE cycle with `x_out=1`.
- Underrun is detected at the edge ending bit 7. EOP begins in the next cycle.

## Test plan
- Reset values: hold `reset`, then release with `data_valid=0` → `x_out=1`, `tx_active=0`, `data_ready=1` indefinitely. Encoder output stays constant.
- Single byte 8'hA5 with `frame_last=1` → `x_out` = 0,0,0,0,0,0,0,1, then 1,0,1,0,0,1,0,1, then 1,1. `frame_done` on cycle 18, `tx_active` high for 18 cycles.
- Byte 8'hFF, last → after sync's trailing 1, five data 1s, then a stuffed 0 (`stuff_bit=1`), then three 1s, then EOP. Total 19 cycles.
- Three bytes 8'h01, 8'h02, 8'h03 offered while `data_ready` is high → `data_ready` drops after each accept and re-rises when the buffer moves to the shifter. No gaps between bytes, no `underrun`. `data_ready` stays low from the last accept until after `frame_done`.
- Underrun: first byte not last, `data_valid` held low afterwards → `underrun` pulses at the end of byte 1, then 2 EOP cycles, then IDLE.
- Mid-frame reset during DATA bit 3 → all outputs reach their reset values immediately. The next frame starts cleanly with the sync pattern.
